ymbus_sched: RTL and testbench

Write scheduler for the local YM2203/SAA1099 bus. It accepts chip-register write requests already decoded from the Speccy AY-slot cycle and queues them in order. It drives the local chip-select, write-strobe and data lines with programmable setup, strobe and hold times. It also enforces per-chip busy recovery: the YM2203 needs 17 or 83 ymclk cycles after an address or data write. It sits between the bus decoder and the `d`/`ymcs*_n`/`saacs_n` pins; reads stay with the bus decoder, which yields the bus through `bus_hold`.

---
 rtl/ymbus_sched_pkg.sv | 22 ++
 rtl/ymbus_fifo.sv | 66 ++++++
 rtl/ymbus_sched.sv | 156 +++++++++++++++
 tb/tb_ymbus_sched.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ymbus_sched_pkg.sv
// rtl/ymbus_sched_pkg.sv - shared types and constants for the YM/SAA write scheduler
package ymbus_sched_pkg;

  localparam logic [1:0] DEV_YM0  = 2'd0;
  localparam logic [1:0] DEV_YM1  = 2'd1;
  localparam logic [1:0] DEV_SAA  = 2'd2;
  localparam logic [1:0] DEV_RSVD = 2'd3;

  localparam int REC_W = 11;
  localparam int T_YM_AWAIT_DEF = 272;
  localparam int T_YM_DWAIT_DEF = 1328;
  localparam int T_SAA_WAIT_DEF = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD} state_t;

  typedef struct packed {
    logic [1:0] dev;
    logic       a0;
    logic [7:0] data;
  } wreq_t;

endpackage

// File: rtl/ymbus_fifo.sv
// rtl/ymbus_fifo.sv - show-ahead request queue; AW=0 collapses to a single holding register
module ymbus_fifo
  import ymbus_sched_pkg::*;
#(
  parameter int AW = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  wreq_t din,
  output wreq_t head,
  output logic  full,
  output logic  empty
);

  if (AW == 0) begin : g_reg
    logic  vld;
    wreq_t r;

    assign full  = vld;
    assign empty = !vld;
    assign head  = r;

    always_ff @(posedge clk) begin
      if (rst) begin
        vld <= 1'b0;
        r   <= '0;
      end else begin
        if (pop && vld)
          vld <= 1'b0;
        if (push && !vld) begin
          vld <= 1'b1;
          r   <= din;
        end
      end
    end
  end else begin : g_ring
    localparam int DEPTH = 1 << AW;
    wreq_t       mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
      if (push && !full)
        mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push && !full)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop && !empty)
          rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ymbus_sched.sv
// rtl/ymbus_sched.sv - YM2203/SAA1099 local-bus write scheduler with recovery timing
// YMBUS_SCHED_FIFO_EN selects a 2^FIFO_AW queue; otherwise a single holding register.
module ymbus_sched
  import ymbus_sched_pkg::*;
#(
  parameter int FIFO_AW    = 2,
  parameter int T_SETUP    = 3,
  parameter int T_WR       = 12,
  parameter int T_HOLD     = 3,
  parameter int T_YM_AWAIT = T_YM_AWAIT_DEF,
  parameter int T_YM_DWAIT = T_YM_DWAIT_DEF,
  parameter int T_SAA_WAIT = T_SAA_WAIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_dev,
  input  logic       req_a0,
  input  logic [7:0] req_data,
  input  logic       bus_hold,
  output logic [7:0] d_out,
  output logic       d_oe,
  output logic       yma0,
  output logic       ymcs0_n,
  output logic       ymcs1_n,
  output logic       ymwr_n,
  output logic       saaa0,
  output logic       saacs_n,
  output logic       saawr_n,
  idle
);

`ifdef YMBUS_SCHED_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif

  wreq_t            head, cur;
  logic             full, empty, push, pop;
  logic             can_go, launch, discard, head_free, hold_done;
  logic             active, ym0_sel, ym1_sel, saa_sel, strobe;
  state_t           state;
  logic [7:0]       phase;
  logic [REC_W-1:0] rec [3];
  logic [REC_W-1:0] rec_load;

  assign req_ready = !full;
  assign push      = req_valid && !full;

  ymbus_fifo #(.AW(FIFO_EN ? FIFO_AW : 0)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ('{dev: req_dev, a0: req_a0, data: req_data}),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    head_free = 1'b1;
    case (head.dev)
      DEV_YM0: head_free = (rec[0] == '0);
      DEV_YM1: head_free = (rec[1] == '0);
      DEV_SAA: head_free = (rec[2] == '0);
      default: head_free = 1'b1;
    endcase
  end

  assign can_go    = (state == ST_IDLE) && !empty && !bus_hold;
  assign discard   = can_go && (head.dev == DEV_RSVD);
  assign launch    = can_go && (head.dev != DEV_RSVD) && head_free;
  assign pop       = launch || discard;
  assign hold_done = (state == ST_HOLD) && (phase == 8'd0);
  assign rec_load  = (cur.dev == DEV_SAA) ? REC_W'(T_SAA_WAIT)
                   : (cur.a0 ? REC_W'(T_YM_DWAIT) : REC_W'(T_YM_AWAIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      phase <= 8'd0;
      cur   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (launch) begin
          cur   <= head;
          phase <= 8'(T_SETUP - 1);
          state <= ST_SETUP;
        end
        ST_SETUP: if (phase == 8'd0) begin
          phase <= 8'(T_WR - 1);
          state <= ST_STROBE;
        end else phase <= phase - 8'd1;
        ST_STROBE: if (phase == 8'd0) begin
          phase <= 8'(T_HOLD - 1);
          state <= ST_HOLD;
        end else phase <= phase - 8'd1;
        default: if (phase == 8'd0) state <= ST_IDLE;
          else phase <= phase - 8'd1;
      endcase
    end
  end

  // Recovery reloads on the HOLD exit edge and otherwise runs down freely.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst)
        rec[i] <= '0;
      else if (hold_done && (cur.dev == 2'(i)))
        rec[i] <= rec_load;
      else if (rec[i] != '0)
        rec[i] <= rec[i] - 1'b1;
    end
  end

  assign active  = (state != ST_IDLE);
  assign strobe  = (state == ST_STROBE);
  assign ym0_sel = active && (cur.dev == DEV_YM0);
  assign ym1_sel = active && (cur.dev == DEV_YM1);
  assign saa_sel = active && (cur.dev == DEV_SAA);

  // Pins are a registered copy of the phase state, one cycle behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ymcs0_n <= 1'b1;
      ymcs1_n <= 1'b1;
      saacs_n <= 1'b1;
      ymwr_n  <= 1'b1;
      saawr_n <= 1'b1;
      d_oe    <= 1'b0;
      d_out   <= 8'h00;
      yma0    <= 1'b0;
      saaa0   <= 1'b0;
    end else begin
      ymcs0_n <= !ym0_sel;
      ymcs1_n <= !ym1_sel;
      saacs_n <= !saa_sel;
      ymwr_n  <= !((ym0_sel || ym1_sel) && strobe);
      saawr_n <= !(saa_sel && strobe);
      d_oe    <= active;
      if (active)
        d_out <= cur.data;
      if (ym0_sel || ym1_sel)
        yma0 <= cur.a0;
      if (saa_sel)
        saaa0 <= cur.a0;
    end
  end

  assign idle = empty && (state == ST_IDLE) &&
                (rec[0] == '0) && (rec[1] == '0) && (rec[2] == '0);

endmodule

// File: tb/tb_ymbus_sched.sv
// tb/tb_ymbus_sched.sv - directed vector bench for ymbus_sched (either YMBUS_SCHED_FIFO_EN build)
module tb_ymbus_sched;
  import ymbus_sched_pkg::*;

`ifdef YMBUS_SCHED_FIFO_EN
  localparam int DEPTH   = 4;
  localparam int REL_LAT = 2;
`else
  localparam int DEPTH   = 1;
  localparam int REL_LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0, req_a0 = 1'b0, bus_hold = 1'b0;
  logic [1:0] req_dev = 2'd0;
  logic [7:0] req_data = 8'h00;
  logic       req_ready, d_oe, yma0, ymcs0_n, ymcs1_n, ymwr_n, saaa0, saacs_n, saawr_n, idle;
  logic [7:0] d_out;

  ymbus_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_dev(req_dev), .req_a0(req_a0), .req_data(req_data), .bus_hold(bus_hold),
    .d_out(d_out), .d_oe(d_oe), .yma0(yma0), .ymcs0_n(ymcs0_n), .ymcs1_n(ymcs1_n),
    .ymwr_n(ymwr_n), .saaa0(saaa0), .saacs_n(saacs_n), .saawr_n(saawr_n), .idle(idle)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0] cs_prev = 3'b111, cs_now;
  logic       ywr_prev = 1'b1, swr_prev = 1'b1;
  int cs_falls [3] = '{0, 0, 0};
  int cs_fall_cyc [3] = '{0, 0, 0};
  int cs_rise_cyc [3] = '{0, 0, 0};
  int ywr_falls = 0, swr_falls = 0;

  always @(negedge clk) begin
    cs_now = {saacs_n, ymcs1_n, ymcs0_n};
    for (int i = 0; i < 3; i++) begin
      if (cs_prev[i] === 1'b1 && cs_now[i] === 1'b0) begin
        cs_falls[i]++;
        cs_fall_cyc[i] = cyc;
      end
      if (cs_prev[i] === 1'b0 && cs_now[i] === 1'b1)
        cs_rise_cyc[i] = cyc;
    end
    if (ywr_prev === 1'b1 && ymwr_n === 1'b0) ywr_falls++;
    if (swr_prev === 1'b1 && saawr_n === 1'b0) swr_falls++;
    cs_prev  = cs_now;
    ywr_prev = ymwr_n;
    swr_prev = saawr_n;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] dev, input logic a0, input logic [7:0] data);
    for (int n = 0; n < 3000 && req_ready !== 1'b1; n++) step();
    if (req_ready !== 1'b1) begin
      check("push_ready_timeout", 32'(req_ready), 1);
      return;
    end
    req_valid = 1'b1; req_dev = dev; req_a0 = a0; req_data = data;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 3000 && idle !== 1'b1; n++) step();
    check("wait_idle", 32'(idle), 1);
  endtask

  typedef struct {
    logic [1:0] dev;
    logic       a0;
    logic [7:0] data;
    int         exp_pin;
    logic [7:0] exp_d;
  } vec_t;

  vec_t vecs [5];
  int   v_cs, v_wr, v_d, v_a0, v_oth, base;
  logic [2:0] csv;
  logic       pin_cs, pin_wr, pin_a0, exp_cs, exp_wr;

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{DEV_YM0, 1'b0, 8'h07, 0, 8'h07};
    vecs[1] = '{DEV_YM1, 1'b1, 8'hA5, 1, 8'hA5};
    vecs[2] = '{DEV_SAA, 1'b0, 8'h1C, 2, 8'h1C};
    vecs[3] = '{DEV_SAA, 1'b1, 8'hFF, 2, 8'hFF};
    vecs[4] = '{DEV_YM0, 1'b1, 8'h00, 0, 8'h00};

    // Reset state
    rst = 1'b1;
    step(); step();
    check("rst_strobes", 32'({ymcs0_n, ymcs1_n, saacs_n, ymwr_n, saawr_n}), 32'h1F);
    check("rst_doe", 32'(d_oe), 0);
    check("rst_dout_a0", 32'({d_out, yma0, saaa0}), 0);
    check("rst_idle", 32'(idle), 1);
    check("rst_ready", 32'(req_ready), 1);
    rst = 1'b0;
    step();

    // Single writes: cs low edges N+2..N+19, strobe N+5..N+16
    for (int v = 0; v < 5; v++) begin
      wait_idle();
      push(vecs[v].dev, vecs[v].a0, vecs[v].data);
      v_cs = 0; v_wr = 0; v_d = 0; v_a0 = 0; v_oth = 0;
      for (int k = 1; k <= 22; k++) begin
        step();
        csv    = {saacs_n, ymcs1_n, ymcs0_n};
        pin_cs = csv[vecs[v].exp_pin];
        pin_wr = (vecs[v].exp_pin == 2) ? saawr_n : ymwr_n;
        pin_a0 = (vecs[v].exp_pin == 2) ? saaa0 : yma0;
        exp_cs = !(k >= 2 && k <= 19);
        exp_wr = !(k >= 5 && k <= 16);
        if (pin_cs !== exp_cs) v_cs++;
        if (pin_wr !== exp_wr) v_wr++;
        if (d_oe !== !exp_cs || (!exp_cs && d_out !== vecs[v].exp_d)) v_d++;
        if (!exp_cs && pin_a0 !== vecs[v].a0) v_a0++;
        for (int p = 0; p < 3; p++)
          if (p != vecs[v].exp_pin && csv[p] !== 1'b1) v_oth++;
      end
      check($sformatf("vec%0d_cs", v), v_cs, 0);
      check($sformatf("vec%0d_wr", v), v_wr, 0);
      check($sformatf("vec%0d_data", v), v_d, 0);
      check($sformatf("vec%0d_a0", v), v_a0, 0);
      check($sformatf("vec%0d_other_cs", v), v_oth, 0);
    end

    // Same-device recovery after a data write: gap of 1328 + 1
    wait_idle();
    base = cs_falls[0];
    push(DEV_YM0, 1'b1, 8'h11);
    push(DEV_YM0, 1'b0, 8'h22);
    for (int n = 0; n < 100 && !(cs_falls[0] == base + 1 && ymcs0_n === 1'b1); n++) step();
    begin
      int r1;
      r1 = cs_rise_cyc[0];
      for (int n = 0; n < 3000 && cs_falls[0] < base + 2; n++) step();
      check("rec_gap", 32'(cs_fall_cyc[0] - r1), 1329);
    end
    check("rec_second_data", 32'(d_out), 32'h22);

    // Other device interleaves after a single idle cycle
    wait_idle();
    base = cs_falls[1];
    push(DEV_YM0, 1'b1, 8'h33);
    push(DEV_YM1, 1'b0, 8'h44);
    for (int n = 0; n < 200 && cs_falls[1] < base + 1; n++) step();
    check("ilv_gap", 32'(cs_fall_cyc[1] - cs_rise_cyc[0]), 1);
    check("ilv_data", 32'(d_out), 32'h44);

    // Queue full under bus_hold
    wait_idle();
    base = cs_falls[0] + cs_falls[1] + cs_falls[2];
    bus_hold = 1'b1;
    begin
      int acc;
      acc = 0;
      req_valid = 1'b1; req_dev = DEV_SAA; req_a0 = 1'b0; req_data = 8'h5A;
      for (int i = 0; i < 5; i++) begin
        if (req_ready === 1'b1) acc++;
        step();
      end
      req_valid = 1'b0;
      check("full_accepts", 32'(acc), 32'(DEPTH));
    end
    check("full_ready", 32'(req_ready), 0);
    repeat (5) step();
    check("full_quiet", 32'(cs_falls[0] + cs_falls[1] + cs_falls[2] - base), 0);
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    bus_hold = 1'b0;
    check("flush_idle", 32'(idle), 1);
    repeat (30) step();
    check("flush_no_launch", 32'(cs_falls[0] + cs_falls[1] + cs_falls[2] - base), 0);

    // Reserved target discarded, then SAA launches after bus_hold release
    wait_idle();
    bus_hold = 1'b1;
    begin
      int fs, sw, yw, ymf, rel;
      fs = cs_falls[2]; sw = swr_falls; yw = ywr_falls; ymf = cs_falls[0] + cs_falls[1];
      push(DEV_RSVD, 1'b0, 8'hEE);
`ifdef YMBUS_SCHED_FIFO_EN
      push(DEV_SAA, 1'b0, 8'h1C);
`endif
      repeat (10) step();
      check("hold_quiet", 32'(cs_falls[2] - fs + cs_falls[0] + cs_falls[1] - ymf), 0);
      bus_hold = 1'b0;
      rel = cyc + 1;
`ifndef YMBUS_SCHED_FIFO_EN
      push(DEV_SAA, 1'b0, 8'h1C);
`endif
      for (int n = 0; n < 100 && cs_falls[2] < fs + 1; n++) step();
      check("rel_latency", 32'(cs_fall_cyc[2] - rel), 32'(REL_LAT));
      check("rel_data", 32'(d_out), 32'h1C);
      for (int n = 0; n < 100 && saacs_n !== 1'b1; n++) step();
      check("rel_saa_strobes", 32'(swr_falls - sw), 1);
      check("rel_ym_quiet", 32'(ywr_falls - yw + cs_falls[0] + cs_falls[1] - ymf), 0);
    end

    // Reset during STROBE aborts and drops the queue
    wait_idle();
    base = cs_falls[0] + cs_falls[1];
    push(DEV_YM1, 1'b0, 8'h55);
    push(DEV_YM0, 1'b0, 8'h66);
`ifdef YMBUS_SCHED_FIFO_EN
    push(DEV_YM0, 1'b1, 8'h77);
`endif
    for (int n = 0; n < 100 && ymwr_n !== 1'b0; n++) step();
    check("mid_in_strobe", 32'(ymwr_n), 0);
    rst = 1'b1;
    req_valid = 1'b1; req_dev = DEV_YM0; req_a0 = 1'b0; req_data = 8'h99;
    step();
    check("mid_rst_pins", 32'({ymwr_n, ymcs0_n, ymcs1_n, d_oe}), 32'hE);
    check("mid_rst_ready", 32'(req_ready), 1);
    step();
    rst = 1'b0;
    req_valid = 1'b0;
    check("mid_rst_idle", 32'(idle), 1);
    repeat (100) step();
    check("mid_no_replay", 32'(cs_falls[0] + cs_falls[1] - base), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
